// File: rtl/jericalla_fetch.sv
// Instruction fetch/issue stage feeding the jericalla datapath main_bus.
// Define JERICALLA_FETCH_HAZARD_STALL_EN to enable RAW scoreboard and bubble insertion.
module jericalla_fetch #(
   parameter int          DEPTH    = 32,
   parameter int          AW       = 5,
   parameter logic [16:0] NOP_WORD = 17'b00_00000_00000_00000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [16:0]   prog_data,
   output logic [16:0]   main_bus,
   output logic          issue_valid,
   output logic [AW-1:0] pc,
   output logic          busy,
   output logic          done,
   output logic [7:0]    bubble_count
);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t        state, state_nxt;
   logic [16:0]   mem [0:DEPTH-1];
   logic [16:0]   word;
   logic [AW-1:0] pc_nxt;
   logic [16:0]   bus_nxt;
   logic          valid_nxt;
   logic          is_halt;
   logic          hazard;
   logic          launch;

   assign word    = mem[pc];
   assign is_halt = (word[16:15] == 2'b11) && (word[14:10] == 5'b11111);
   assign launch  = start && (state != RUN);
   assign busy    = (state == RUN);
   assign done    = (state == HALT);

`ifdef JERICALLA_FETCH_HAZARD_STALL_EN
   // sb_*[0] is the word issued last cycle, sb_*[1] the one before it.
   logic [1:0] sb_v;
   logic [4:0] sb_wa [0:1];
   logic       push_v;

   assign hazard = (sb_v[0] && ((word[9:5] == sb_wa[0]) || (word[4:0] == sb_wa[0]))) ||
                   (sb_v[1] && ((word[9:5] == sb_wa[1]) || (word[4:0] == sb_wa[1])));
   assign push_v = valid_nxt && (word[16:15] != 2'b11) && (word[14:10] != 5'd0);

   always_ff @(posedge clk) begin
      if (reset || launch) begin
         bubble_count <= 8'd0;
         sb_v         <= 2'b00;
         sb_wa[0]     <= 5'd0;
         sb_wa[1]     <= 5'd0;
      end else if (state == RUN) begin
         if (!is_halt && hazard && (bubble_count != 8'hff))
            bubble_count <= bubble_count + 8'd1;
         sb_v     <= {sb_v[0], push_v};
         sb_wa[1] <= sb_wa[0];
         sb_wa[0] <= word[14:10];
      end
   end
`else
   assign hazard       = 1'b0;
   assign bubble_count = 8'd0;
`endif

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      bus_nxt   = NOP_WORD;
      valid_nxt = 1'b0;
      case (state)
         IDLE, HALT: begin
            if (start) begin
               state_nxt = RUN;
               pc_nxt    = '0;
            end
         end
         RUN: begin
            if (is_halt) begin
               state_nxt = HALT;
            end else if (!hazard) begin
               bus_nxt   = word;
               valid_nxt = 1'b1;
               // The last word ends the program; PC parks on it rather than wrapping.
               if (pc == AW'(DEPTH - 1))
                  state_nxt = HALT;
               else
                  pc_nxt = pc + AW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         pc          <= '0;
         main_bus    <= NOP_WORD;
         issue_valid <= 1'b0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         main_bus    <= bus_nxt;
         issue_valid <= valid_nxt;
      end
   end

   // Program memory has no reset so contents survive a mid-run reset.
   always_ff @(posedge clk) begin
      if (prog_we && (state != RUN))
         mem[prog_addr] <= prog_data;
   end

endmodule

// File: tb/tb_jericalla_fetch.sv
// Self-checking bench for jericalla_fetch against a slot/distance reference model.
// Follows JERICALLA_FETCH_HAZARD_STALL_EN the same way the design does.
module tb_jericalla_fetch;

   localparam logic [16:0] NOP  = 17'b0;
   localparam logic [16:0] HALT = 17'b11_11111_00000_00000;
`ifdef JERICALLA_FETCH_HAZARD_STALL_EN
   localparam bit HZ = 1'b1;
`else
   localparam bit HZ = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        prog_we = 1'b0;
   logic [4:0]  prog_addr = '0;
   logic [16:0] prog_data = '0;
   logic [16:0] main_bus;
   logic        issue_valid;
   logic [4:0]  pc;
   logic        busy;
   logic        done;
   logic [7:0]  bubble_count;

   int n_cmp = 0;
   int n_bad = 0;

   logic [16:0] shadow [0:31];
   logic [18:0] exp_q[$];   // {done, issue_valid, main_bus} per sampled cycle
   int          exp_pc;
   int          exp_bub;

   jericalla_fetch dut (
      .clk(clk), .reset(reset), .start(start), .prog_we(prog_we),
      .prog_addr(prog_addr), .prog_data(prog_data), .main_bus(main_bus),
      .issue_valid(issue_valid), .pc(pc), .busy(busy), .done(done),
      .bubble_count(bubble_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_bus"}, 32'(main_bus), 32'(NOP));
      check({tag, "_valid"}, 32'(issue_valid), 0);
      check({tag, "_pc"}, 32'(pc), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_bub"}, 32'(bubble_count), 0);
   endtask

   task automatic load_word(input int addr, input logic [16:0] data);
      @(negedge clk);
      prog_we   = 1'b1;
      prog_addr = 5'(addr);
      prog_data = data;
      shadow[addr] = data;
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   // A source register may be read only once its last write issued >= 3 slots earlier.
   task automatic build_expect();
      int slot = 0;
      int p = 0;
      int bub = 0;
      int last_wr [0:31];
      logic [16:0] w;
      for (int r = 0; r < 32; r++) last_wr[r] = -1000;
      exp_q.delete();
      while (slot < 2000) begin
         w = shadow[p];
         if (w[16:15] == 2'b11 && w[14:10] == 5'd31) begin
            exp_q.push_back({1'b1, 1'b0, NOP});
            exp_pc = p;
            break;
         end
         if (HZ && ((slot - last_wr[w[9:5]] < 3) || (slot - last_wr[w[4:0]] < 3))) begin
            exp_q.push_back({1'b0, 1'b0, NOP});
            bub++;
            slot++;
            continue;
         end
         if (w[16:15] != 2'b11 && w[14:10] != 5'd0) last_wr[w[14:10]] = slot;
         if (p == 31) begin
            exp_q.push_back({1'b1, 1'b1, w});
            exp_pc = 31;
            break;
         end
         exp_q.push_back({1'b0, 1'b1, w});
         p++;
         slot++;
      end
      exp_bub = (bub > 255) ? 255 : bub;
   endtask

   // poke_at: slot at which a program write is attempted mid-run (-1 none).
   // reset_at: slot after which reset is pulsed (-1 none).
   task automatic run_prog(input string tag, input int poke_at, input int reset_at,
                           input bit co_wr, input int co_addr, input logic [16:0] co_data);
      logic [18:0] e;
      int k = 0;
      @(negedge clk);
      start = 1'b1;
      if (co_wr) begin
         prog_we   = 1'b1;
         prog_addr = 5'(co_addr);
         prog_data = co_data;
         shadow[co_addr] = co_data;
      end
      build_expect();
      @(negedge clk);
      start   = 1'b0;
      prog_we = 1'b0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front();
         check({tag, "_slot"}, 32'({done, issue_valid, main_bus}), 32'(e));
         if (k == reset_at) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check_reset_vals({tag, "_midrst"});
            return;
         end
         if (k == poke_at) begin
            prog_we   = 1'b1;
            prog_addr = 5'd0;
            prog_data = 17'b00_01001_01001_01001;
         end else begin
            prog_we = 1'b0;
         end
         k++;
      end
      prog_we = 1'b0;
      check({tag, "_done"}, 32'(done), 1);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_pc"}, 32'(pc), 32'(exp_pc));
      check({tag, "_bub"}, 32'(bubble_count), 32'(exp_bub));
   endtask

   function automatic logic [16:0] rand_word(input int rmax);
      logic [1:0] op = 2'($urandom_range(0, 3));
      logic [4:0] wa = 5'($urandom_range(0, rmax));
      logic [4:0] a  = 5'($urandom_range(0, rmax));
      logic [4:0] b  = 5'($urandom_range(0, rmax));
      return {op, wa, a, b};
   endfunction

   initial begin
      for (int i = 0; i < 32; i++) shadow[i] = HALT;
      // reset and idle
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_reset_vals("rst");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_busy", 32'({busy, done, issue_valid}), 0);
      end
      check_reset_vals("idle_end");

      // distance-1 hazard
      load_word(0, 17'b00_00100_00000_00001);
      load_word(1, 17'b11_00000_00111_00100);
      load_word(2, HALT);
      run_prog("dist1", -1, -1, 1'b0, 0, NOP);
      check("dist1_bub_abs", 32'(bubble_count), HZ ? 2 : 0);

      // distance-2 hazard
      load_word(0, 17'b00_00101_00001_00010);
      load_word(1, 17'b01_00110_00001_00010);
      load_word(2, 17'b10_00111_00101_00011);
      load_word(3, HALT);
      run_prog("dist2", -1, -1, 1'b0, 0, NOP);
      check("dist2_bub_abs", 32'(bubble_count), HZ ? 1 : 0);

      // WA = 0 and SW never create a dependency
      load_word(0, 17'b00_00000_00001_00010);
      load_word(1, 17'b01_00011_00000_00000);
      load_word(2, 17'b11_00100_00001_00010);
      load_word(3, 17'b00_00101_00100_00100);
      load_word(4, HALT);
      run_prog("nostall", -1, -1, 1'b0, 0, NOP);
      check("nostall_bub_abs", 32'(bubble_count), 0);

      // full memory of independent words: runs off the end without wrapping
      for (int i = 0; i < 32; i++)
         load_word(i, {2'($urandom_range(0, 2)), 5'($urandom_range(16, 30)),
                       5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))});
      run_prog("fill", -1, -1, 1'b0, 0, NOP);
      check("fill_pc_abs", 32'(pc), 31);

      // random dependent programs
      for (int t = 0; t < 12; t++) begin
         int len = $urandom_range(3, 20);
         for (int i = 0; i < len; i++) load_word(i, rand_word(7));
         load_word(len, HALT);
         run_prog("rand", -1, -1, 1'b0, 0, NOP);
      end

      // mid-run write is ignored; the rerun must match the untouched program
      for (int i = 0; i < 8; i++) load_word(i, rand_word(3));
      load_word(8, HALT);
      run_prog("poke", 2, -1, 1'b0, 0, NOP);
      run_prog("poke_rerun", -1, -1, 1'b0, 0, NOP);

      // reset mid-run, then start with a simultaneous program write from IDLE
      load_word(0, 17'b00_00100_00000_00001);
      load_word(1, 17'b11_00000_00111_00100);
      load_word(2, HALT);
      run_prog("midrst", -1, 1, 1'b0, 0, NOP);
      run_prog("cowr", -1, -1, 1'b1, 1, 17'b01_00110_00100_00100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/jericalla_fetch.md
# jericalla_fetch

Instruction fetch and issue stage that sits directly upstream of the jericalla datapath and drives its 17-bit `main_bus`. It holds a small instruction memory loaded through a program port and steps a program counter. Each cycle it issues one instruction, or a NOP bubble when a read-after-write hazard against the datapath's two-stage delayed register write-back is detected. A HALT word or the end of memory stops issue.

## Interface
- `DEPTH`, 32, instruction memory words
- `AW`, 5, PC / program address width; `DEPTH` = 2^`AW`
- `NOP_WORD`, 17'b00_00000_00000_00000, word driven on bubbles (add r0 = r0 + r0; r0 is reserved scratch)

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle pulse; begins execution at PC 0
- `prog_we`  in  1  program write enable
- `prog_addr`  in  `AW`  program write address
- `prog_data`  in  17  program write data
- `main_bus`  out  17  registered instruction to the datapath: [16:15] opcode, [14:10] WA, [9:5] RA_A, [4:0] RA_B
- `issue_valid`  out  1  1 = `main_bus` holds a real program instruction; 0 = bubble or idle
- `pc`  out  `AW`  address of the next instruction to fetch
- `busy`  out  1  high in RUN
- `done`  out  1  high in HALT
- `bubble_count`  out  8  bubbles inserted since last start; saturates at 255

## Operation
- FSM states: IDLE, RUN, HALT. Reset → IDLE.
- IDLE: `start` → RUN with PC = 0, scoreboard cleared, `bubble_count` = 0.
- RUN: once per cycle, examine `mem[pc]`:
  - The word is HALT when opcode = 2'b11 and WA = 5'b11111. It is not issued. Go to HALT and drive `NOP_WORD` with `issue_valid` = 0.
  - Hazard means the word's RA_A or RA_B equals a valid scoreboard WA. All opcodes are checked, including SW (11). On a hazard, drive `NOP_WORD` with `issue_valid` = 0, hold PC, and increment `bubble_count`.
  - Otherwise issue the word with `issue_valid` = 1 and PC + 1.
  - After issuing `mem[DEPTH-1]`, go to HALT. PC never wraps.
- Scoreboard: a 2-entry shift register of {write_valid, WA}, shifted every RUN cycle.
  - The new entry is {1, WA} for an issued instruction with opcode ≠ 2'b11 and WA ≠ 0.
  - The new entry is {0, x} for a bubble or an SW.
  - Result: a dependency at distance 1 costs 2 bubbles, at distance 2 costs 1 bubble, at distance ≥ 3 costs none.
- HALT: `done` = 1. `start` → RUN (same as from IDLE).
- `start` is ignored in RUN.
- `prog_we` is accepted only in IDLE/HALT (write `mem[prog_addr]` = `prog_data`) and is ignored in RUN.
- Memory is not cleared by reset. Contents are undefined until programmed.

## Timing
- Reset values: `main_bus` = `NOP_WORD`, `issue_valid` = 0, `pc` = 0, `busy` = 0, `done` = 0, `bubble_count` = 0, scoreboard invalid, state IDLE.
- `start` sampled at edge N → first instruction visible on `main_bus` after edge N+1. The fetch read is combinational from `mem[pc]`; the `main_bus` register is loaded at edge N+1.
- Steady state: one word (instruction or bubble) per cycle.
- A program write at edge N is visible to a `start` at edge N+1 or later.
- `start` and `prog_we` in the same IDLE cycle: the write happens and the FSM enters RUN. The written word is fetched if its address is reached.
- `reset` mid-RUN: the next edge forces all reset values. The in-flight instruction is abandoned and the memory is intact.
- HALT detected and hazard on the same word: HALT takes priority, no bubble is counted.

## Configuration
- `JERICALLA_FETCH_HAZARD_STALL_EN` defined: scoreboard and bubble insertion as above.
- Not defined: no scoreboard. Every non-HALT word is issued back-to-back and `bubble_count` is tied to 0. Software must place its own NOPs.

## Test plan
- Reset/idle: assert `reset` 2 cycles → `main_bus` = 17'h00000, `issue_valid` = 0, `pc` = 0, `busy` = 0, `done` = 0. No change for 10 cycles without `start`.
- Distance-1 hazard: load `mem[0]` = 00_00100_00000_00001, `mem[1]` = 11_00000_00111_00100, `mem[2]` = HALT 11_11111_00000_00000, then start → `issue_valid` sequence 1,0,0,1. `main_bus` shows `mem[0]`, 2×NOP, `mem[1]`. Then `done` = 1 and `bubble_count` = 2.
- Distance-2 hazard: `mem[0]` writes r5, `mem[1]` independent (writes r6 from r1,r2), `mem[2]` reads r5 → exactly 1 bubble before `mem[2]`, `bubble_count` = 1.
- No hazard / end of memory: fill all 32 words with independent adds (WA distinct from all RA) → 32 consecutive `issue_valid` = 1 cycles, then `done` = 1, `pc` = 31, no wrap to 0.
- WA = 0 and SW never stall: `mem[0]` writes r0, `mem[1]` reads r0 → 0 bubbles. `mem[2]` = SW with WA field 00100, `mem[3]` reads r4 → 0 bubbles.
- Reset mid-run and restart: `reset` during a bubble → reset values on the next edge. `prog_we` during RUN is ignored, verified by reading back the program after `start`. Start after HALT re-runs from PC 0 with `bubble_count` reset.
- Macro off: rerun the distance-1 program → `issue_valid` 1,1 then `done`, `bubble_count` = 0.
